hazard_scoreboard: RTL and testbench

Producer-side companion to the execute-stage operand bypass. It tracks the destination register, write-enable and load flag of every in-flight instruction in the Execute, Memory and Writeback stages. From that state it generates the forwarding selects the execute bypass consumes, the load-use stall, and the branch flush. It sits beside the pipeline registers in the top-level core and advances in lockstep with them.

---
 rtl/hazard_scoreboard.sv | 109 ++++++++++
 tb/tb_hazard_scoreboard.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks the E/M/W writers, drives the execute forwarding selects, the load-use stall and the branch flush.
// Latency: all controls are combinational from Decode inputs and slot state; slots and counters advance on every clock.
// Backpressure: a load-use dependency holds F/D for one cycle and bubbles D/E; a taken branch overrides the stall.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  d_valid,
    input  logic [REG_ADDR_W-1:0] d_rs1,
    input  logic [REG_ADDR_W-1:0] d_rs2,
    input  logic                  d_uses_rs1,
    input  logic                  d_uses_rs2,
    input  logic [REG_ADDR_W-1:0] d_rd,
    input  logic                  d_reg_we,
    input  logic                  d_is_load,
    input  logic                  e_branch_taken,
    output logic                  stall_fd,
    output logic                  bubble_de,
    output logic                  flush_fd,
    output logic [1:0]            fwd_rs1_sel,
    output logic [1:0]            fwd_rs2_sel,
    output logic                  wb_rs1_hit,
    output logic                  wb_rs2_hit,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    // The load flag only matters while the load sits in E, so older slots keep just the writer fields.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
    } slot_t;

    typedef struct packed {
        slot_t                 base;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  uses_rs1;
        logic                  uses_rs2;
    } e_slot_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    e_slot_t e_slot;
    slot_t   m_slot;
    slot_t   w_slot;
    logic    load_use;

    function automatic logic is_writer(input slot_t s);
        return s.valid && s.we && (s.rd != '0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic e_valid, input logic uses,
                                           input logic [REG_ADDR_W-1:0] rs,
                                           input slot_t m, input slot_t w);
        logic [1:0] sel;
        sel = 2'b00;
        if (e_valid && uses && is_writer(m) && (m.rd == rs))
            sel = 2'b01;
        else if (e_valid && uses && is_writer(w) && (w.rd == rs))
            sel = 2'b10;
        return sel;
    endfunction

    assign load_use = d_valid && is_writer(e_slot.base) && e_slot.is_load &&
                      ((d_uses_rs1 && (d_rs1 == e_slot.base.rd)) ||
                       (d_uses_rs2 && (d_rs2 == e_slot.base.rd)));

    // Gated by reset so every output reads 0 while reset is held, even with a branch input asserted.
    assign flush_fd  = e_branch_taken && reset_n;
    assign stall_fd  = load_use && !flush_fd;
    assign bubble_de = load_use || flush_fd;

    assign fwd_rs1_sel = fwd_sel(e_slot.base.valid, e_slot.uses_rs1, e_slot.rs1, m_slot, w_slot);
    assign fwd_rs2_sel = fwd_sel(e_slot.base.valid, e_slot.uses_rs2, e_slot.rs2, m_slot, w_slot);

    assign wb_rs1_hit = d_valid && d_uses_rs1 && is_writer(w_slot) && (w_slot.rd == d_rs1);
    assign wb_rs2_hit = d_valid && d_uses_rs2 && is_writer(w_slot) && (w_slot.rd == d_rs2);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            e_slot      <= '0;
            m_slot      <= '0;
            w_slot      <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            w_slot              <= m_slot;
            m_slot              <= e_slot.base;
            e_slot.base.valid   <= d_valid && !bubble_de;
            e_slot.base.rd      <= d_rd;
            e_slot.base.we      <= d_reg_we;
            e_slot.is_load      <= d_is_load;
            e_slot.rs1          <= d_rs1;
            e_slot.rs2          <= d_rs2;
            e_slot.uses_rs1     <= d_uses_rs1;
            e_slot.uses_rs2     <= d_uses_rs2;
            if (stall_fd && (stall_count != '1))
                stall_count <= stall_count + CNT_ONE;
            if (flush_fd && (flush_count != '1))
                flush_count <= flush_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: the driver queues hand-computed expectations per cycle; a monitor pops and compares each settled cycle.
module tb_hazard_scoreboard;

    logic        clock;
    logic        reset_n;
    logic        d_valid;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic        d_uses_rs1, d_uses_rs2, d_reg_we, d_is_load, e_branch_taken;
    logic        stall_fd, bubble_de, flush_fd, wb_rs1_hit, wb_rs2_hit;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic [31:0] stall_count, flush_count;

    typedef struct {
        logic [8:0] out;
        int         sc;
        int         fc;
        string      name;
    } exp_t;

    exp_t q[$];
    int   tests;
    int   failed;

    hazard_scoreboard #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
        .d_rd(d_rd), .d_reg_we(d_reg_we), .d_is_load(d_is_load),
        .e_branch_taken(e_branch_taken),
        .stall_fd(stall_fd), .bubble_de(bubble_de), .flush_fd(flush_fd),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .wb_rs1_hit(wb_rs1_hit), .wb_rs2_hit(wb_rs2_hit),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output vector layout: {stall, bubble, flush, sel1[1:0], sel2[1:0], hit1, hit2}
    task automatic cyc(input string name, input logic rn, input logic v,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic we, input logic ld, input logic br,
                       input logic [8:0] eo, input int sc, input int fc);
        exp_t e;
        @(posedge clock);
        #1;
        reset_n = rn; d_valid = v; d_rs1 = rs1; d_rs2 = rs2;
        d_uses_rs1 = u1; d_uses_rs2 = u2; d_rd = rd; d_reg_we = we;
        d_is_load = ld; e_branch_taken = br;
        e.out = eo; e.sc = sc; e.fc = fc; e.name = name;
        q.push_back(e);
    endtask

    task automatic idle(input string name, input logic [8:0] eo, input int sc, input int fc);
        cyc(name, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, eo, sc, fc);
    endtask

    // Reset asserted between clock edges, with Decode inputs left as they were.
    task automatic rst_mid(input string name);
        exp_t e;
        @(negedge clock);
        #2;
        e.out = 9'b0; e.sc = 0; e.fc = 0; e.name = name;
        q.push_back(e);
        reset_n = 1'b0;
    endtask

    initial begin
        exp_t       e;
        logic [8:0] act;
        forever begin
            @(negedge clock or negedge reset_n);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {stall_fd, bubble_de, flush_fd, fwd_rs1_sel, fwd_rs2_sel, wb_rs1_hit, wb_rs2_hit};
                tests++;
                if (act !== e.out) begin
                    failed++;
                    $display("FAIL %s outputs: got %b expected %b", e.name, act, e.out);
                end
                tests++;
                if (stall_count !== e.sc) begin
                    failed++;
                    $display("FAIL %s stall_count: got %0d expected %0d", e.name, stall_count, e.sc);
                end
                tests++;
                if (flush_count !== e.fc) begin
                    failed++;
                    $display("FAIL %s flush_count: got %0d expected %0d", e.name, flush_count, e.fc);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; d_valid = 1'b0; d_rs1 = '0; d_rs2 = '0; d_rd = '0;
        d_uses_rs1 = 1'b0; d_uses_rs2 = 1'b0; d_reg_we = 1'b0; d_is_load = 1'b0;
        e_branch_taken = 1'b0;
        tests = 0; failed = 0;

        cyc("rst_hold", 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 9'b0, 0, 0);
        idle("idle0", 9'b0, 0, 0);
        idle("idle1", 9'b0, 0, 0);
        idle("idle2", 9'b0, 0, 0);

        // ALU chain: add x5; sub x6,x5,x1; or x10,x5,x0
        cyc("alu_add", 1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 9'b0, 0, 0);
        cyc("alu_sub", 1'b1, 1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 9'b0, 0, 0);
        cyc("alu_or",  1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 9'b000_01_00_00, 0, 0);
        idle("fwd_w", 9'b000_10_00_00, 0, 0);
        idle("drain0", 9'b0, 0, 0);
        idle("drain1", 9'b0, 0, 0);

        // Load-use: lw x7; add x8,x7,x7 held one cycle by the stall
        cyc("lw",       1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 9'b0, 0, 0);
        cyc("lu_stall", 1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 9'b110_00_00_00, 0, 0);
        cyc("lu_held",  1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 9'b0, 1, 0);
        idle("lu_fwd", 9'b000_10_10_00, 1, 0);
        idle("lu_drain", 9'b0, 1, 0);
        cyc("wb_x8", 1'b1, 1'b1, 5'd8, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 9'b000_00_00_10, 1, 0);
        idle("drain2", 9'b0, 1, 0);
        idle("drain3", 9'b0, 1, 0);
        idle("drain4", 9'b0, 1, 0);

        // x0 guard: ALU and load writers to x0 never forward or stall
        cyc("addi_x0", 1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 9'b0, 1, 0);
        cyc("add_x0",  1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 9'b0, 1, 0);
        cyc("lw_x0",   1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 9'b0, 1, 0);
        cyc("dep_x0",  1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 9'b0, 1, 0);
        idle("x0_e", 9'b0, 1, 0);
        idle("x0_m", 9'b0, 1, 0);
        idle("x0_w", 9'b0, 1, 0);

        // Flush priority over a load-use stall in the same cycle
        cyc("lw_f",      1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 9'b0, 1, 0);
        cyc("flush_pri", 1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 9'b011_00_00_00, 1, 0);
        idle("post_flush", 9'b0, 1, 1);
        idle("drain5", 9'b0, 1, 1);
        idle("drain6", 9'b0, 1, 1);

        // Decode-side Writeback bypass on x3
        cyc("addi_x3", 1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 9'b0, 1, 1);
        idle("x3_e", 9'b0, 1, 1);
        idle("x3_m", 9'b0, 1, 1);
        cyc("wb_x3", 1'b1, 1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 9'b000_00_00_10, 1, 1);
        idle("x3_after", 9'b0, 1, 1);

        // M and W both write x4: the newer M value wins
        cyc("addi_x4a", 1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 9'b0, 1, 1);
        cyc("addi_x4b", 1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 9'b0, 1, 1);
        cyc("add_x11",  1'b1, 1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 9'b0, 1, 1);
        idle("mw_same_rd", 9'b000_01_01_00, 1, 1);
        idle("drain7", 9'b0, 1, 1);
        idle("drain8", 9'b0, 1, 1);

        // Reset in the middle of a stall, then held low with a branch pending
        cyc("lw_r",      1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 9'b0, 1, 1);
        cyc("lu_stall2", 1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 9'b110_00_00_00, 1, 1);
        rst_mid("rst_mid_stall");
        cyc("rst_low", 1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 9'b0, 0, 0);
        idle("rst_release", 9'b0, 0, 0);
        cyc("br_only", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 9'b011_00_00_00, 0, 0);
        idle("br_count", 9'b0, 0, 1);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
        if (q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
